// File: rtl/mbssoc_apic_pkg.sv
// Shared definitions for the MBSsoc interrupt router and core-start controller.
package mbssoc_apic_pkg;

   localparam int unsigned CORE_NUM_DEF  = 2;
   localparam int unsigned SYSCODE_WIDTH = 4;

   typedef enum logic [SYSCODE_WIDTH-1:0] {
      SYS_NOP        = 4'd0,
      SYS_START_CORE = 4'd1
   } sys_code_e;

   typedef enum logic {
      CORE_IDLE = 1'b0,
      CORE_BUSY = 1'b1
   } core_state_e;

endpackage

// File: rtl/mbssoc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the slot after the last grant.
module mbssoc_rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] grant_idx;
   logic          found;

   always_comb begin
      int unsigned idx;
      grant     = '0;
      grant_idx = ptr_q;
      found     = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (32'(ptr_q) + i) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (advance && found) begin
         ptr_q <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mbssoc_int_router.sv
// Multi-core interrupt router with fixed-priority dispatch and serialised core-start syscalls.
module mbssoc_int_router
   import mbssoc_apic_pkg::*;
#(
   parameter int unsigned             SRC_NUM    = 8,
   parameter int unsigned             CORE_NUM   = CORE_NUM_DEF,
   parameter int unsigned             SRC_W      = $clog2(SRC_NUM),
   parameter int unsigned             ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]   BOOT_PC    = 112
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [SRC_NUM-1:0]                    irq_src,
   output logic [SRC_NUM-1:0]                    src_ack,
   input  logic [CORE_NUM*SRC_NUM-1:0]           route_mask,
   input  logic [CORE_NUM-1:0]                   core_int_en,
   output logic [CORE_NUM-1:0]                   core_int,
   output logic [CORE_NUM*SRC_W-1:0]             core_int_id,
   input  logic [CORE_NUM-1:0]                   core_eoi,
   input  logic [CORE_NUM-1:0]                   sys_valid,
   input  logic [CORE_NUM*SYSCODE_WIDTH-1:0]     sys_code,
   input  logic [CORE_NUM*$clog2(CORE_NUM)-1:0]  sys_target,
   input  logic [CORE_NUM*ADDR_WIDTH-1:0]        sys_data,
   output logic [CORE_NUM-1:0]                   sys_ack,
   output logic [CORE_NUM*ADDR_WIDTH-1:0]        core_pc,
   output logic [CORE_NUM-1:0]                   core_start
);

   localparam int unsigned TW = $clog2(CORE_NUM);

   logic [SRC_NUM-1:0]     irq_q, pending_q, rise, src_clr, src_ack_q;
   logic [CORE_NUM-1:0]    src_elig [SRC_NUM];
   logic [CORE_NUM-1:0]    idle, disp_elig, core_grant;
   logic                   disp_valid;
   logic [SRC_W-1:0]       disp_src;
   core_state_e            state_q [CORE_NUM];
   core_state_e            state_d [CORE_NUM];
   logic [SRC_W-1:0]       int_id_q [CORE_NUM];

   logic                   sel_valid;
   logic [CORE_NUM-1:0]    sel_onehot, start_d, sys_ack_q, core_start_q;
   logic [SYSCODE_WIDTH-1:0] sel_code;
   logic [TW-1:0]          sel_target;
   logic [ADDR_WIDTH-1:0]  sel_data;
   logic [ADDR_WIDTH-1:0]  core_pc_q [CORE_NUM];

   assign rise = irq_src & ~irq_q;

   always_comb begin
      for (int unsigned c = 0; c < CORE_NUM; c++) begin
         idle[c] = (state_q[c] == CORE_IDLE);
      end
      for (int unsigned i = 0; i < SRC_NUM; i++) begin
         for (int unsigned c = 0; c < CORE_NUM; c++) begin
            src_elig[i][c] = idle[c] & core_int_en[c] & route_mask[c*SRC_NUM + i];
         end
      end
   end

   // A pending source with no eligible core is skipped so lower priorities still proceed.
   always_comb begin
      disp_valid = 1'b0;
      disp_src   = '0;
      disp_elig  = '0;
      src_clr    = '0;
      for (int unsigned i = 0; i < SRC_NUM; i++) begin
         if (!disp_valid && pending_q[i] && (|src_elig[i])) begin
            disp_valid = 1'b1;
            disp_src   = SRC_W'(i);
            disp_elig  = src_elig[i];
            src_clr[i] = 1'b1;
         end
      end
   end

   mbssoc_rr_arbiter #(
      .N (CORE_NUM)
   ) u_core_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (disp_elig),
      .advance (disp_valid),
      .grant   (core_grant)
   );

   always_comb begin
      for (int unsigned c = 0; c < CORE_NUM; c++) begin
         state_d[c] = state_q[c];
         unique case (state_q[c])
            CORE_IDLE: if (core_grant[c]) state_d[c] = CORE_BUSY;
            CORE_BUSY: if (core_eoi[c])   state_d[c] = CORE_IDLE;
            default:   state_d[c] = CORE_IDLE;
         endcase
      end
   end

   // New edges win over the dispatch clear, so an event arriving in the dispatch cycle survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q     <= '0;
         pending_q <= '0;
         src_ack_q <= '0;
         for (int unsigned c = 0; c < CORE_NUM; c++) begin
            state_q[c]  <= CORE_IDLE;
            int_id_q[c] <= '0;
         end
      end else begin
         irq_q     <= irq_src;
         pending_q <= (pending_q & ~src_clr) | rise;
         src_ack_q <= src_clr;
         for (int unsigned c = 0; c < CORE_NUM; c++) begin
            state_q[c] <= state_d[c];
            if (core_grant[c]) int_id_q[c] <= disp_src;
         end
      end
   end

   // Requesters already acked this cycle still hold sys_valid and must not be re-served.
   always_comb begin
      sel_valid  = 1'b0;
      sel_onehot = '0;
      sel_code   = '0;
      sel_target = '0;
      sel_data   = '0;
      for (int unsigned i = 0; i < CORE_NUM; i++) begin
         if (!sel_valid && sys_valid[i] && !sys_ack_q[i]) begin
            sel_valid     = 1'b1;
            sel_onehot[i] = 1'b1;
            sel_code      = sys_code[i*SYSCODE_WIDTH +: SYSCODE_WIDTH];
            sel_target    = sys_target[i*TW +: TW];
            sel_data      = sys_data[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
      for (int unsigned c = 0; c < CORE_NUM; c++) begin
         start_d[c] = sel_valid && (sel_code == SYS_START_CORE) && (sel_target == TW'(c));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sys_ack_q    <= '0;
         core_start_q <= '0;
         for (int unsigned c = 0; c < CORE_NUM; c++) begin
            core_pc_q[c] <= (c == 0) ? '0 : BOOT_PC;
         end
      end else begin
         sys_ack_q    <= sel_onehot;
         core_start_q <= start_d;
         for (int unsigned c = 0; c < CORE_NUM; c++) begin
            if (start_d[c]) core_pc_q[c] <= sel_data;
         end
      end
   end

   always_comb begin
      core_int    = '0;
      core_int_id = '0;
      core_pc     = '0;
      for (int unsigned c = 0; c < CORE_NUM; c++) begin
         core_int[c]                          = (state_q[c] == CORE_BUSY);
         core_int_id[c*SRC_W +: SRC_W]        = int_id_q[c];
         core_pc[c*ADDR_WIDTH +: ADDR_WIDTH]  = core_pc_q[c];
      end
   end

   assign src_ack    = src_ack_q;
   assign sys_ack    = sys_ack_q;
   assign core_start = core_start_q;

endmodule

// File: tb/tb_mbssoc_int_router.sv
// Directed self-checking bench for mbssoc_int_router (8 sources, 2 cores).
module tb_mbssoc_int_router;

   localparam int unsigned SRC_NUM  = 8;
   localparam int unsigned CORE_NUM = 2;
   localparam int unsigned SRC_W    = 3;
   localparam int unsigned AW       = 32;
   localparam int unsigned CW       = 4;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [SRC_NUM-1:0]         irq_src;
   logic [SRC_NUM-1:0]         src_ack;
   logic [CORE_NUM*SRC_NUM-1:0] route_mask;
   logic [CORE_NUM-1:0]        core_int_en;
   logic [CORE_NUM-1:0]        core_int;
   logic [CORE_NUM*SRC_W-1:0]  core_int_id;
   logic [CORE_NUM-1:0]        core_eoi;
   logic [CORE_NUM-1:0]        sys_valid;
   logic [CORE_NUM*CW-1:0]     sys_code;
   logic [CORE_NUM-1:0]        sys_target;
   logic [CORE_NUM*AW-1:0]     sys_data;
   logic [CORE_NUM-1:0]        sys_ack;
   logic [CORE_NUM*AW-1:0]     core_pc;
   logic [CORE_NUM-1:0]        core_start;

   int n_assert = 0;
   int n_fail   = 0;

   mbssoc_int_router #(
      .SRC_NUM    (SRC_NUM),
      .CORE_NUM   (CORE_NUM),
      .SRC_W      (SRC_W),
      .ADDR_WIDTH (AW),
      .BOOT_PC    (32'd112)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_src     (irq_src),
      .src_ack     (src_ack),
      .route_mask  (route_mask),
      .core_int_en (core_int_en),
      .core_int    (core_int),
      .core_int_id (core_int_id),
      .core_eoi    (core_eoi),
      .sys_valid   (sys_valid),
      .sys_code    (sys_code),
      .sys_target  (sys_target),
      .sys_data    (sys_data),
      .sys_ack     (sys_ack),
      .core_pc     (core_pc),
      .core_start  (core_start)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      irq_src     = '0;
      route_mask  = '1;
      core_int_en = '1;
      core_eoi    = '0;
      sys_valid   = '0;
      sys_code    = '0;
      sys_target  = '0;
      sys_data    = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic eoi(input logic [CORE_NUM-1:0] m);
      core_eoi = m;
      tick();
      core_eoi = '0;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      // Reset values
      check("rst_core_int", core_int, 2'b00);
      check("rst_src_ack", src_ack, 8'h00);
      check("rst_int_id", core_int_id, 6'h00);
      check("rst_sys_ack", sys_ack, 2'b00);
      check("rst_start", core_start, 2'b00);
      check("rst_pc", core_pc, {32'd112, 32'd0});
      rst_n = 1'b1;

      // Single source 3
      irq_src[3] = 1'b1;
      tick();
      check("s3_not_yet", core_int, 2'b00);
      tick();
      check("s3_int", core_int, 2'b01);
      check("s3_id", core_int_id[2:0], 3'd3);
      check("s3_ack", src_ack, 8'h08);
      tick();
      check("s3_ack_pulse", src_ack, 8'h00);
      check("s3_held", core_int, 2'b01);
      irq_src = '0;
      eoi(2'b01);
      check("s3_eoi", core_int, 2'b00);

      // Sources 1 and 5 together
      do_reset();
      irq_src = 8'h22;
      tick();
      tick();
      check("p15_first_int", core_int, 2'b01);
      check("p15_first_id", core_int_id[2:0], 3'd1);
      check("p15_first_ack", src_ack, 8'h02);
      tick();
      check("p15_second_int", core_int, 2'b11);
      check("p15_second_id", core_int_id[5:3], 3'd5);
      check("p15_second_ack", src_ack, 8'h20);
      irq_src = '0;
      eoi(2'b11);
      check("p15_eoi", core_int, 2'b00);

      // Round-robin on source 2: cores 0,1,0,1,0
      do_reset();
      for (int k = 0; k < 5; k++) begin
         irq_src[2] = 1'b1;
         tick();
         tick();
         check("rr_core", core_int, (k % 2 == 0) ? 2'b01 : 2'b10);
         check("rr_ack", src_ack, 8'h04);
         irq_src[2] = 1'b0;
         eoi(core_int);
         check("rr_eoi", core_int, 2'b00);
      end

      // Masking: source 4 only on core 1, source 7 only on core 1
      do_reset();
      route_mask = {8'b1001_0000, 8'b0110_1111};
      irq_src[7] = 1'b1;
      tick();
      tick();
      check("mask_s7_core1", core_int, 2'b10);
      check("mask_s7_id", core_int_id[5:3], 3'd7);
      irq_src[4] = 1'b1;
      irq_src[6] = 1'b1;
      tick();
      tick();
      check("mask_s6_core0", core_int, 2'b11);
      check("mask_s6_id", core_int_id[2:0], 3'd6);
      check("mask_s6_ack", src_ack, 8'h40);
      tick();
      check("mask_s4_waits", src_ack, 8'h00);
      eoi(2'b10);
      check("mask_core1_idle", core_int, 2'b01);
      check("mask_no_ack_at_eoi", src_ack, 8'h00);
      tick();
      check("mask_s4_core1", core_int, 2'b11);
      check("mask_s4_id", core_int_id[5:3], 3'd4);
      check("mask_s4_ack", src_ack, 8'h10);
      irq_src = '0;
      eoi(2'b11);

      // Coalesce: two edges on source 0 while no core is enabled
      do_reset();
      core_int_en = 2'b00;
      irq_src[0] = 1'b1; tick();
      irq_src[0] = 1'b0; tick();
      irq_src[0] = 1'b1; tick();
      irq_src[0] = 1'b0; tick();
      check("coal_blocked", core_int, 2'b00);
      core_int_en = 2'b01;
      tick();
      check("coal_dispatch", core_int, 2'b01);
      check("coal_ack", src_ack, 8'h01);
      eoi(2'b01);
      tick();
      tick();
      check("coal_single_int", core_int, 2'b00);
      check("coal_single_ack", src_ack, 8'h00);

      // Retain: new edge sampled in the dispatch cycle
      core_int_en = 2'b00;
      irq_src[0] = 1'b1; tick();
      irq_src[0] = 1'b0; tick();
      core_int_en = 2'b01;
      irq_src[0] = 1'b1;
      tick();
      check("ret_first_int", core_int, 2'b01);
      check("ret_first_ack", src_ack, 8'h01);
      irq_src[0] = 1'b0;
      tick();
      check("ret_wait_ack", src_ack, 8'h00);
      eoi(2'b01);
      check("ret_eoi", core_int, 2'b00);
      tick();
      check("ret_second_int", core_int, 2'b01);
      check("ret_second_ack", src_ack, 8'h01);
      check("ret_second_id", core_int_id[2:0], 3'd0);
      eoi(2'b01);

      // Syscalls: both cores start core 1
      do_reset();
      sys_valid  = 2'b11;
      sys_code   = {4'd1, 4'd1};
      sys_target = 2'b11;
      sys_data   = {32'h300, 32'h200};
      tick();
      check("sys_ack0", sys_ack, 2'b01);
      check("sys_pc_200", core_pc, {32'h200, 32'h0});
      check("sys_start0", core_start, 2'b10);
      sys_valid[0] = 1'b0;
      tick();
      check("sys_ack1", sys_ack, 2'b10);
      check("sys_pc_300", core_pc, {32'h300, 32'h0});
      check("sys_start1", core_start, 2'b10);
      sys_valid[1] = 1'b0;
      tick();
      check("sys_ack_done", sys_ack, 2'b00);
      check("sys_start_done", core_start, 2'b00);

      // Unknown code: acked with no effect
      sys_valid = 2'b01; sys_code = {4'd0, 4'd5}; sys_target = 2'b00; sys_data = {32'h0, 32'habc};
      tick();
      check("sys_unk_ack", sys_ack, 2'b01);
      check("sys_unk_start", core_start, 2'b00);
      check("sys_unk_pc", core_pc, {32'h300, 32'h0});
      sys_valid = '0;
      tick();

      // Self-target start
      sys_valid = 2'b01; sys_code = {4'd0, 4'd1}; sys_target = 2'b00; sys_data = {32'h0, 32'h44};
      tick();
      check("sys_self_start", core_start, 2'b01);
      check("sys_self_pc", core_pc, {32'h300, 32'h44});
      sys_valid = '0;
      tick();

      // Asynchronous reset mid-run drops pending and restores boot PCs
      irq_src[3] = 1'b1;
      tick();
      rst_n = 1'b0;
      irq_src = '0;
      #2;
      check("arst_pc", core_pc, {32'd112, 32'd0});
      check("arst_int", core_int, 2'b00);
      rst_n = 1'b1;
      tick();
      tick();
      check("arst_lost_int", core_int, 2'b00);
      check("arst_lost_ack", src_ack, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
